exhaustive_tt_checker: RTL
==========================

EXHAUSTIVE_TT_CHECKER -- requirements
Module: exhaustive_tt_checker

Interface
REQ-001 Parameter: EXP_TABLE, 16'hD668, expected {x,y} per vector; entry i = EXP_TABLE[2i+1:2i], bit 2i+1 = x, bit 2i = y, i = {a,b,c}.
REQ-002 Parameter: SETTLE, 10, settle cycles per vector, legal range 1..255.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a sweep.
REQ-006 x  input  1  DUT output x, sampled by checker.
REQ-007 y  input  1  DUT output y, sampled by checker.
REQ-008 a  output  1  stimulus MSB, driven from registered vector bit 2.
REQ-009 b  output  1  stimulus, vector bit 1.
REQ-010 c  output  1  stimulus LSB, vector bit 0.
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 done  output  1  one-cycle pulse at end of sweep.
REQ-013 pass  output  1  high when last completed sweep had zero mismatches.
REQ-014 err_count  output  4  mismatches in current/last sweep, 0..8.
REQ-015 fail_vec  output  3  vector index of first mismatch.
REQ-016 fail_x, fail_y  output  1 each  DUT x,y values captured at first mismatch.

Function
REQ-017 FSM states IDLE, SETTLE, DONE; state, vector, and settle counter are registers.
REQ-018 IDLE: busy=0, {a,b,c}=000; start=1 -> vector=0, counter=SETTLE-1, err_count=0, pass=0, fail_* cleared, state SETTLE.
REQ-019 SETTLE: busy=1, {a,b,c}=vector; counter decrements each cycle while nonzero.
REQ-020 Sample point: SETTLE with counter=0; x,y compared against EXP_TABLE entry for current vector in that cycle.
REQ-021 Mismatch: err_count increments; if err_count was 0, fail_vec=vector, fail_x=x, fail_y=y captured.
REQ-022 Sample point with vector<7: vector increments, counter reloads to SETTLE-1, state stays SETTLE.
REQ-023 Sample point with vector=7: state DONE; vector does not wrap.
REQ-024 DONE: done=1 for exactly one cycle, busy=0, pass=1 iff err_count=0 (including a vector-7 mismatch); next state IDLE.
REQ-025 Each vector held exactly SETTLE cycles; start accepted at edge T -> done high in cycle T+8*SETTLE+1 (first SETTLE cycle = T+1).
REQ-026 start while busy or in DONE ignored; no restart, no counter disturbance.
REQ-027 pass, err_count, fail_vec, fail_x, fail_y hold after DONE until next accepted start or rst.
REQ-028 err_count saturates at 8 by construction (max 8 samples); no overflow.

Reset
REQ-029 rst=1 at a clock edge -> state IDLE; a,b,c,busy,done,pass,fail_x,fail_y=0; err_count=0; fail_vec=0; counter=0.
REQ-030 rst takes priority over start and over a sample point in the same cycle; a sweep interrupted by rst is abandoned, no done pulse.

Verification
REQ-031 Full-adder DUT (x=a^b^c, y=majority), SETTLE=10, start -> {a,b,c} steps 000..111 every 10 cycles, done 81 cycles after start edge, pass=1, err_count=0.
REQ-032 Same, y stuck at 0 -> err_count=4, fail_vec=3, fail_x=0, fail_y=0, pass=0.
REQ-033 SETTLE=1, correct DUT -> new vector every cycle, done 9 cycles after start edge, pass=1.
REQ-034 start pulsed again at vector 4 mid-sweep -> ignored; single done at normal time, results unchanged.
REQ-035 rst asserted while vector=4 -> next cycle {a,b,c}=000, busy=0, err_count=0, no done; subsequent start runs full clean sweep.
REQ-036 Fault only at vector 7 (x forced 0 at {a,b,c}=111) -> err_count=1, fail_vec=7, fail_x=0, fail_y=1, pass=0 in the DONE cycle.

Source files
------------

// File: rtl/exhaustive_tt_checker.sv
// exhaustive_tt_checker: sweeps {a,b,c} over all 8 vectors and checks x,y against a truth table
module exhaustive_tt_checker #(
  parameter logic [15:0] EXP_TABLE = 16'hD668,
  parameter int          SETTLE    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       x,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec,
  output logic       fail_x,
  output logic       fail_y
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [7:0] RELOAD   = 8'(SETTLE - 1);
  logic [1:0]  r_state;
  logic [2:0]  r_vec;
  logic [7:0]  r_cnt;
  logic        r_pass;
  logic [3:0]  r_err;
  logic [2:0]  r_fvec;
  logic        r_fx;
  logic        r_fy;
  logic [15:0] w_sh;
  logic        w_mis;
  assign w_sh      = EXP_TABLE >> {r_vec, 1'b0};
  assign w_mis     = {x, y} != w_sh[1:0];
  assign busy      = r_state == S_SETTLE;
  assign done      = r_state == S_DONE;
  assign {a, b, c} = busy ? r_vec : 3'd0;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fvec;
  assign fail_x    = r_fx;
  assign fail_y    = r_fy;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec   <= 3'd0;
      r_cnt   <= 8'd0;
      r_pass  <= 1'b0;
      r_err   <= 4'd0;
      r_fvec  <= 3'd0;
      r_fx    <= 1'b0;
      r_fy    <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_state <= S_SETTLE;
      r_vec   <= 3'd0;
      r_cnt   <= RELOAD;
      r_pass  <= 1'b0;
      r_err   <= 4'd0;
      r_fvec  <= 3'd0;
      r_fx    <= 1'b0;
      r_fy    <= 1'b0;
    end else if (r_state == S_SETTLE) begin
      if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
      else begin
        if (w_mis) begin
          r_err <= r_err + 4'd1;
          if (r_err == 4'd0) begin
            r_fvec <= r_vec;
            r_fx   <= x;
            r_fy   <= y;
          end
        end
        if (r_vec == 3'd7) begin
          r_state <= S_DONE;
          r_pass  <= !w_mis && r_err == 4'd0;
        end else begin
          r_vec <= r_vec + 3'd1;
          r_cnt <= RELOAD;
        end
      end
    end else if (r_state == S_DONE) r_state <= S_IDLE;
  end
endmodule
